// File: rtl/bch_chien_pkg.sv
// Shared definitions for the serial Chien search: code-parameter packing,
// GF(2^m) constant multiply, FSM state encoding.
package bch_chien_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] bch_params(int data_bits, int t);
      return {16'(data_bits), 16'(t)};
   endfunction

   function automatic int bch_t(logic [31:0] p);
      return int'(p[15:0]);
   endfunction

   function automatic int bch_data(logic [31:0] p);
      return int'(p[31:16]);
   endfunction

   // smallest field whose codeword length fits data + parity
   function automatic int bch_m(logic [31:0] p);
      int m;
      m = 8;
      for (int i = 8; i >= 2; i--)
         if (bch_data(p) + i * bch_t(p) <= (1 << i) - 1) m = i;
      return m;
   endfunction

   function automatic int bch_n(logic [31:0] p);
      return (1 << bch_m(p)) - 1;
   endfunction

   function automatic int bch_code_bits(logic [31:0] p);
      return bch_data(p) + bch_m(p) * bch_t(p);
   endfunction

   // first evaluated point is alpha^-(CODE_BITS-1)
   function automatic int bch_init_exp(logic [31:0] p);
      return bch_n(p) - bch_code_bits(p) + 1;
   endfunction

   function automatic int BCH_SIGMA_SZ(logic [31:0] p);
      return (bch_t(p) + 1) * bch_m(p);
   endfunction

   function automatic int BCH_ERR_SZ(logic [31:0] p);
      return (bch_t(p) < 1) ? 1 : $clog2(bch_t(p) + 1);
   endfunction

   function automatic int prim_poly(int m);
      case (m)
         2:       return 'h7;
         3:       return 'hB;
         4:       return 'h13;
         5:       return 'h25;
         6:       return 'h43;
         7:       return 'h89;
         default: return 'h11D;
      endcase
   endfunction

   function automatic logic [15:0] gf_xtime(int m, logic [15:0] v);
      logic [16:0] s;
      s = {v, 1'b0};
      if (s[m]) s = s ^ 17'(prim_poly(m));
      return s[15:0];
   endfunction

   // value * alpha^exponent; constant exponent folds to an XOR network
   function automatic logic [15:0] gf_mul_const(int m, logic [15:0] value,
                                                int exponent);
      logic [15:0] v;
      int          e;
      e = exponent % ((1 << m) - 1);
      v = value;
      for (int i = 0; i < 255; i++)
         if (i < e) v = gf_xtime(m, v);
      return v;
   endfunction

endpackage

// File: rtl/bch_chien_term.sv
// One Chien term register: loads sigma_j*alpha^(J*INIT_EXP), steps by alpha^J.
// Ports: clk, reset, load_i, step_i, sig_i (coefficient), term_o (register).
module bch_chien_term
   import bch_chien_pkg::*;
#(
   parameter int M        = 5,
   parameter int J        = 1,
   parameter int INIT_EXP = 12
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [M-1:0] sig_i,
   output logic [M-1:0] term_o
);

   logic [M-1:0] term_q, term_d;

   always_comb begin
      term_d = term_q;
      if (load_i)
         term_d = M'(gf_mul_const(M, 16'(sig_i), J * INIT_EXP));
      else if (step_i)
         term_d = M'(gf_mul_const(M, 16'(term_q), J));
   end

   always_ff @(posedge clk) begin
      if (reset) term_q <= '0;
      else       term_q <= term_d;
   end

   assign term_o = term_q;

endmodule

// File: rtl/bch_chien_serial.sv
// Serial Chien search: captures sigma from the BMA, streams one error flag
// per data bit (err/first/last under err_valid/err_ready), then done/fail.
// Ports: clk, reset (sync, high), start/sigma/err_count/ack_done/ready
// from the solver, err_* stream to the corrector, done/fail at the end.
// Option BCH_CHIEN_ERRCHK_EN: fail when located count != err_count.
module bch_chien_serial
   import bch_chien_pkg::*;
#(
   parameter int          T         = 3,
   parameter int          DATA_BITS = 5,
   parameter logic [31:0] P         = bch_params(DATA_BITS, T)
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [BCH_SIGMA_SZ(P)-1:0] sigma,
   input  logic [BCH_ERR_SZ(P)-1:0]   err_count,
   output logic                       ack_done,
   output logic                       ready,
   output logic                       err_valid,
   input  logic                       err_ready,
   output logic                       err,
   output logic                       first,
   output logic                       last,
   output logic                       done,
   output logic                       fail
);

   localparam int M        = bch_m(P);
   localparam int EW       = BCH_ERR_SZ(P);
   localparam int INIT_EXP = bch_init_exp(P);
   localparam int KW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [M-1:0]  s0_q, s0_d;
   logic          ack_q, ack_d;
   logic          load, step;
   logic [M-1:0]  term_w [T];
   logic [M-1:0]  syn;
   logic          err_w;

   for (genvar j = 1; j <= T; j++) begin : g_term
      bch_chien_term #(
         .M        (M),
         .J        (j),
         .INIT_EXP (INIT_EXP)
      ) u_term (
         .clk    (clk),
         .reset  (reset),
         .load_i (load),
         .step_i (step),
         .sig_i  (sigma[j*M +: M]),
         .term_o (term_w[j-1])
      );
   end

   always_comb begin
      syn = s0_q;
      for (int j = 0; j < T; j++) syn = syn ^ term_w[j];
      err_w = (state_q == S_RUN) && (syn == '0);
   end

`ifdef BCH_CHIEN_ERRCHK_EN
   logic [EW-1:0] found_q, found_d, found_nx;
   logic [EW-1:0] cnt_q, cnt_d;
   logic          fail_q, fail_d;
`endif

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      s0_d    = s0_q;
      ack_d   = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
`ifdef BCH_CHIEN_ERRCHK_EN
      found_d  = found_q;
      cnt_d    = cnt_q;
      fail_d   = fail_q;
      found_nx = (found_q == EW'(T)) ? found_q : found_q + EW'(err_w);
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               s0_d    = sigma[M-1:0];
               k_d     = '0;
               ack_d   = 1'b1;
               state_d = S_RUN;
`ifdef BCH_CHIEN_ERRCHK_EN
               found_d = '0;
               cnt_d   = err_count;
`endif
            end
         end
         S_RUN: begin
            if (err_ready) begin
               step = 1'b1;
               k_d  = k_q + 1'b1;
`ifdef BCH_CHIEN_ERRCHK_EN
               found_d = found_nx;
`endif
               if (k_q == KW'(DATA_BITS - 1)) begin
                  k_d     = '0;
                  state_d = S_DONE;
`ifdef BCH_CHIEN_ERRCHK_EN
                  fail_d = (found_nx != cnt_q) || (32'(cnt_q) > T);
`endif
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         s0_q    <= '0;
         ack_q   <= 1'b0;
`ifdef BCH_CHIEN_ERRCHK_EN
         found_q <= '0;
         cnt_q   <= '0;
         fail_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         s0_q    <= s0_d;
         ack_q   <= ack_d;
`ifdef BCH_CHIEN_ERRCHK_EN
         found_q <= found_d;
         cnt_q   <= cnt_d;
         fail_q  <= fail_d;
`endif
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign ack_done  = ack_q;
   assign err_valid = (state_q == S_RUN);
   assign err       = err_w;
   assign first     = err_valid && (k_q == '0);
   assign last      = err_valid && (k_q == KW'(DATA_BITS - 1));
   assign done      = (state_q == S_DONE);

`ifdef BCH_CHIEN_ERRCHK_EN
   assign fail = done && fail_q;
`else
   logic unused_cnt;
   assign unused_cnt = ^err_count;
   assign fail       = 1'b0;
`endif

endmodule

// File: tb/tb_bch_chien_serial.sv
// Directed bench for bch_chien_serial (T=3, DATA_BITS=5, GF(32)).
// Honours BCH_CHIEN_ERRCHK_EN for the expected fail flag.
module tb_bch_chien_serial;

   logic        clk = 1'b0;
   logic        reset, start, err_ready;
   logic [19:0] sigma;
   logic [1:0]  err_count;
   logic        ack_done, ready, err_valid, err, first, last, done, fail;

   int n_tot = 0;
   int n_bad = 0;
   int alog [31];

`ifdef BCH_CHIEN_ERRCHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   always #5 clk = ~clk;

   bch_chien_serial dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sigma     (sigma),
      .err_count (err_count),
      .ack_done  (ack_done),
      .ready     (ready),
      .err_valid (err_valid),
      .err_ready (err_ready),
      .err       (err),
      .first     (first),
      .last      (last),
      .done      (done),
      .fail      (fail)
   );

   task automatic check(string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] pk(int s3, int s2, int s1, int s0);
      return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
   endfunction

   // entered and left at a negedge with the DUT idle
   task automatic run_case(string nm, input logic [19:0] sg,
                           input logic [1:0] ec, input logic [4:0] mask,
                           input bit xfail, input bit stall,
                           input bit poke, input int abort_k);
      int k;
      int cyc;
      bit rdy;
      check({nm, ":ready_in"}, 32'(ready), 1);
      sigma     = sg;
      err_count = ec;
      start     = 1'b1;
      err_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      k     = 0;
      check({nm, ":ack"}, 32'(ack_done), 1);
      check({nm, ":busy"}, 32'(ready), 0);
      while (k < 5 && cyc < 40) begin
         if (k == abort_k) begin
            reset = 1'b1;
            @(negedge clk);
            reset     = 1'b0;
            err_ready = 1'b1;
            check({nm, ":rst_ready"}, 32'(ready), 1);
            check({nm, ":rst_valid"}, 32'(err_valid), 0);
            check({nm, ":rst_err"}, 32'(err), 0);
            check({nm, ":rst_fl"}, 32'({first, last}), 0);
            check({nm, ":rst_done"}, 32'({done, fail, ack_done}), 0);
            return;
         end
         check({nm, ":valid"}, 32'(err_valid), 1);
         check($sformatf("%s:err%0d", nm, k), 32'(err), 32'(mask[k]));
         check({nm, ":first"}, 32'(first), 32'(k == 0));
         check({nm, ":last"}, 32'(last), 32'(k == 4));
         if (cyc == 2) check({nm, ":ack_pulse"}, 32'(ack_done), 0);
         if (poke && cyc == 3) check({nm, ":ack_busy"}, 32'(ack_done), 0);
         start = poke && (cyc == 2);
         rdy   = stall ? cyc[0] : 1'b1;
         err_ready = rdy;
         if (rdy) k++;
         @(negedge clk);
         cyc++;
      end
      start     = 1'b0;
      err_ready = 1'b1;
      check({nm, ":done"}, 32'(done), 1);
      check({nm, ":done_cyc"}, 32'(cyc), stall ? 10 : 6);
      check({nm, ":fail"}, 32'(fail), 32'(xfail));
      check({nm, ":valid_end"}, 32'(err_valid), 0);
      @(negedge clk);
      check({nm, ":done_pulse"}, 32'(done), 0);
      check({nm, ":ready_out"}, 32'(ready), 1);
   endtask

   initial begin
      int a;
      a = 1;
      for (int i = 0; i < 31; i++) begin
         alog[i] = a;
         a = a << 1;
         if (a & 32) a = a ^ 'h25;
      end
      reset     = 1'b1;
      start     = 1'b0;
      err_ready = 1'b0;
      sigma     = '0;
      err_count = '0;
      repeat (2) @(negedge clk);
      check("reset:ready", 32'(ready), 1);
      check("reset:ack", 32'(ack_done), 0);
      check("reset:valid", 32'(err_valid), 0);
      check("reset:err", 32'(err), 0);
      check("reset:fl", 32'({first, last}), 0);
      check("reset:df", 32'({done, fail}), 0);
      reset = 1'b0;

      run_case("clean", pk(0, 0, 0, 1), 2'd0, 5'b00000, 0, 0, 0, -1);
      run_case("single", pk(0, 0, alog[17], 1), 2'd1, 5'b00100,
               0, 0, 0, -1);
      run_case("two", pk(0, alog[3], alog[19] ^ alog[15], 1), 2'd2,
               5'b10001, 0, 0, 1, -1);
      run_case("stall", pk(0, alog[3], alog[19] ^ alog[15], 1), 2'd2,
               5'b10001, 0, 1, 0, -1);
      run_case("abort", pk(0, 0, alog[17], 1), 2'd1, 5'b00100,
               0, 0, 0, 2);
      run_case("after_rst", pk(0, 0, alog[17], 1), 2'd1, 5'b00100,
               0, 0, 0, -1);
      run_case("three", pk(alog[20], alog[4] ^ alog[3] ^ alog[2],
               alog[18] ^ alog[17] ^ alog[16], 1), 2'd3, 5'b01110,
               0, 0, 0, -1);
      run_case("ecc_pos", pk(0, 0, alog[3], 1), 2'd1, 5'b00000,
               CHK, 0, 0, -1);
      run_case("cnt_bad", pk(0, 0, alog[17], 1), 2'd2, 5'b00100,
               CHK, 0, 0, -1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/bch_chien_serial.md
# bch_chien_serial

Serial Chien search stage directly downstream of the serial BMA sigma solver. It captures the error-locator polynomial and error count, and acknowledges the solver via `ack_done`. It then evaluates sigma at every data-bit position, one position per accepted cycle, and emits a per-bit error flag stream that the correction XOR stage consumes.

## Interface
- `T`, 3, correctable errors.
- `DATA_BITS`, 5, data bits per codeword.
- `P`, `bch_params(DATA_BITS, T)`, packed code parameters. Derived: field width M; N = 2^M−1; CODE_BITS = DATA_BITS + M·T. Default P gives M=5, N=31, CODE_BITS=20.
- `clk` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: sigma/err_count valid (BMA done).
- `sigma` input `BCH_SIGMA_SZ(P)`: (T+1)·M bits; coefficient j is at bits [j·M +: M]; sigma_0 is 1.
- `err_count` input `BCH_ERR_SZ(P)`: error count from BMA.
- `ack_done` output 1: one-cycle pulse on capture.
- `ready` output 1: idle, able to capture.
- `err_valid` output 1: err/first/last valid.
- `err_ready` input 1: consumer accepts.
- `err` output 1: data bit k is in error.
- `first`, `last` output 1: k==0 / k==DATA_BITS−1.
- `done` output 1: one-cycle pulse after the last bit is accepted.
- `fail` output 1: qualified by `done`; uncorrectable result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `ready`=1. When `start` is sampled high:
  - load register j ← sigma_j·α^(j·(N−CODE_BITS+1)) for j=1..T;
  - latch sigma_0; k←0; found←0;
  - pulse `ack_done`; go to RUN.
- RUN: `err_valid`=1.
  - `err` = (sigma_0 ⊕ ⊕_j reg_j) == 0, combinational from the registers.
  - Output index k corresponds to codeword degree CODE_BITS−1−k.
  - On `err_valid`&&`err_ready`: reg_j ← reg_j·α^j; k++; found += err, saturating at T.
  - When k==DATA_BITS−1 and the bit is accepted, go to DONE.
  - When `err_ready`=0, all state holds and the outputs stay stable.
- DONE: pulse `done` with `fail`, then go to IDLE.
- `start` while not IDLE is ignored; no capture and no `ack_done`.
- Reset, including mid-RUN, gives: IDLE, `ready`=1. All of `ack_done`, `err_valid`, `err`, `first`, `last`, `done`, `fail` are 0, and k=0.
- The ECC-bit positions (k ≥ DATA_BITS) are never evaluated. Errors located there do not count toward `found`.

## Timing
- `start` sampled in cycle t:
  - `ack_done`=1 and `ready`=0 in t+1;
  - k=0 valid in t+1.
- With `err_ready` held high, bit k is valid in cycle t+1+k. `done` is in t+1+DATA_BITS and `ready`=1 in t+2+DATA_BITS.
- Throughput: one bit per accepted cycle. A back-to-back `start` is captured in the cycle `ready` returns.
- GF constant multipliers are combinational XOR networks, one per register. There is no multi-cycle path.

## Configuration
- `BCH_CHIEN_ERRCHK_EN` defined:
  - `fail` = (found ≠ latched err_count) OR (err_count > T);
  - `fail` is registered into DONE.
- Not defined: `fail` is tied 0; the found counter and the err_count latch are removed.

## Structure
- Shared package `bch_chien_pkg`:
  - field-width and CODE_BITS derivation functions;
  - `gf_mul_const(M, value, exponent)` function;
  - state enum localparams;
  - initial-exponent constant N−CODE_BITS+1.
- One sub-module `bch_chien_term`: one sigma register with its load constant α^(j·(N−CODE_BITS+1)) and its step constant α^j. It is instantiated T times via generate.

## Test plan
- No errors: sigma = {0,0,0,1}, err_count=0 → five bits, all `err`=0; `first` on k=0, `last` on k=4; `done`=1, `fail`=0 in t+6.
- Single error at data bit 2 (degree 17): sigma_1=α^17, other high terms 0, err_count=1 → `err`=1 only at k=2; `fail`=0.
- Two errors at data bits 0 and 4: sigma = (1+α^19x)(1+α^15x), err_count=2 → `err` at k=0 and k=4 only; `fail`=0.
- Backpressure: the two-error case with `err_ready` low in alternate cycles → identical err sequence, outputs stable while stalled, `done` at t+10.
- Reset asserted at k=2 → next cycle: `ready`=1, `err_valid`=0; a subsequent `start` restarts at k=0 with correct flags.
- `BCH_CHIEN_ERRCHK_EN`: single-error sigma (α^17) with err_count=2 → `fail`=1 with `done`. Without the macro → `fail`=0.
